// File: rtl/zigzag_dequant_row_packer_if.sv
// Stream bundle (data/valid/last/ready) shared by the coefficient input
// and the row output of zigzag_dequant_row_packer.
interface zigzag_dequant_row_packer_if #(
    parameter int W = 12
);
    logic [W-1:0] tdata;
    logic         tvalid;
    logic         tlast;
    logic         tready;

    modport master (output tdata, output tvalid, output tlast, input tready);
    modport slave  (input tdata, input tvalid, input tlast, output tready);
endinterface

// File: rtl/zigzag_dequant_row_packer.sv
// Zigzag coefficient dequantizer and row packer feeding the wide IDCT.
// Optional ZZ_EOB_ZERO_FILL_EN: tlast ends a block early, unwritten positions read as 0.
module zdrp_lane #(
    parameter int WIN = 12
) (
    input  logic [WIN-1:0] din,
    input  logic           keep,
    output logic [WIN-1:0] dout
);
    assign dout = keep ? din : '0;
endmodule

module zigzag_dequant_row_packer #(
    parameter int WCOEF = 12,
    parameter int WQ    = 8,
    parameter int WIN   = 12
) (
    input  logic                            clock,
    input  logic                            reset_n,
    input  logic                            qt_we,
    input  logic [5:0]                      qt_addr,
    input  logic [WQ-1:0]                   qt_data,
    zigzag_dequant_row_packer_if.slave      slave,
    zigzag_dequant_row_packer_if.master     master
);
    localparam int WP = WCOEF + WQ + 1;
    localparam logic signed [WP-1:0] MAXV = WP'((2 ** (WIN - 1)) - 1);
    localparam logic signed [WP-1:0] MINV = WP'(-(2 ** (WIN - 1)));

    // Zigzag scan index -> natural position (row*8+col).
    localparam logic [5:0] ZZ [64] = '{
         0,  1,  8, 16,  9,  2,  3, 10,
        17, 24, 32, 25, 18, 11,  4,  5,
        12, 19, 26, 33, 40, 48, 41, 34,
        27, 20, 13,  6,  7, 14, 21, 28,
        35, 42, 49, 56, 57, 50, 43, 36,
        29, 22, 15, 23, 30, 37, 44, 51,
        58, 59, 52, 45, 38, 31, 39, 46,
        53, 60, 61, 54, 47, 55, 62, 63
    };

    logic [WQ-1:0]         qt_q  [64];
    logic [WQ-1:0]         qt_d  [64];
    logic [WIN-1:0]        mem_q [2][64];
    logic [WIN-1:0]        mem_d [2][64];
    logic [1:0]            full_q, full_d;
    logic                  fill_ptr_q, fill_ptr_d;
    logic                  drain_ptr_q, drain_ptr_d;
    logic [5:0]            k_q, k_d;
    logic [2:0]            r_q, r_d;

    logic                  accept, drain_fire, eob;
    logic [5:0]            pos;
    logic signed [WP-1:0]  coef_x, q_x, prod;
    logic [WIN-1:0]        sat_val;

`ifdef ZZ_EOB_ZERO_FILL_EN
    logic [1:0][63:0]      mask_q, mask_d;
    assign eob = slave.tlast;
`else
    logic                  eob_unused;
    assign eob_unused = slave.tlast;
    assign eob = 1'b0;
`endif

    assign slave.tready  = !full_q[fill_ptr_q];
    assign accept        = slave.tvalid && slave.tready;
    assign master.tvalid = full_q[drain_ptr_q];
    assign master.tlast  = master.tvalid && (r_q == 3'd7);
    assign drain_fire    = master.tvalid && master.tready;
    assign pos           = ZZ[k_q];

    // Quant value is zero-extended so it multiplies as a non-negative signed operand.
    always_comb begin
        coef_x = WP'($signed(slave.tdata));
        q_x    = WP'($signed({1'b0, qt_q[k_q]}));
        prod   = coef_x * q_x;
        if (prod > MAXV)      sat_val = MAXV[WIN-1:0];
        else if (prod < MINV) sat_val = MINV[WIN-1:0];
        else                  sat_val = prod[WIN-1:0];
    end

    always_comb begin
        qt_d        = qt_q;
        mem_d       = mem_q;
        full_d      = full_q;
        fill_ptr_d  = fill_ptr_q;
        drain_ptr_d = drain_ptr_q;
        k_d         = k_q;
        r_d         = r_q;
`ifdef ZZ_EOB_ZERO_FILL_EN
        mask_d      = mask_q;
`endif
        if (qt_we) qt_d[qt_addr] = qt_data;

        if (accept) begin
            mem_d[fill_ptr_q][pos] = sat_val;
`ifdef ZZ_EOB_ZERO_FILL_EN
            mask_d[fill_ptr_q][pos] = 1'b1;
`endif
            k_d = k_q + 6'd1;
            if (k_q == 6'd63 || eob) begin
                full_d[fill_ptr_q] = 1'b1;
                fill_ptr_d         = !fill_ptr_q;
                k_d                = 6'd0;
            end
        end

        // Fill and drain never target the same bank in one cycle.
        if (drain_fire) begin
            r_d = r_q + 3'd1;
            if (r_q == 3'd7) begin
                full_d[drain_ptr_q] = 1'b0;
                drain_ptr_d         = !drain_ptr_q;
`ifdef ZZ_EOB_ZERO_FILL_EN
                mask_d[drain_ptr_q] = '0;
`endif
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            for (int i = 0; i < 64; i++) begin
                qt_q[i]     <= WQ'(1);
                mem_q[0][i] <= '0;
                mem_q[1][i] <= '0;
            end
            full_q      <= '0;
            fill_ptr_q  <= 1'b0;
            drain_ptr_q <= 1'b0;
            k_q         <= '0;
            r_q         <= '0;
`ifdef ZZ_EOB_ZERO_FILL_EN
            mask_q      <= '0;
`endif
        end else begin
            qt_q        <= qt_d;
            mem_q       <= mem_d;
            full_q      <= full_d;
            fill_ptr_q  <= fill_ptr_d;
            drain_ptr_q <= drain_ptr_d;
            k_q         <= k_d;
            r_q         <= r_d;
`ifdef ZZ_EOB_ZERO_FILL_EN
            mask_q      <= mask_d;
`endif
        end
    end

    // Column 0 lands in the top slice of the row word.
    for (genvar c = 0; c < 8; c++) begin : g_col
        logic keep;
`ifdef ZZ_EOB_ZERO_FILL_EN
        assign keep = mask_q[drain_ptr_q][{r_q, 3'(c)}];
`else
        assign keep = 1'b1;
`endif
        zdrp_lane #(.WIN(WIN)) u_lane (
            .din  (mem_q[drain_ptr_q][{r_q, 3'(c)}]),
            .keep (keep),
            .dout (master.tdata[(7 - c) * WIN +: WIN])
        );
    end
endmodule
